// File: rtl/flag_unit.sv
// flag_unit
// Status-flag register with a per-flag write mask, a 4-bit branch condition
// evaluator and an optional LIFO flag stack for interrupt save/restore.
//
// Optional feature macro: FLAG_STACK_EN
//   defined   -> stack storage, count, push/pop and sticky stack_err exist
//   undefined -> push/pop ignored, stack_full=0, stack_empty=1, stack_err=0
//
// Parameters:
//   WIDTH  ALU result width (>=2)
//   DEPTH  flag-stack entries (>=1)
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   we, wmask              flag write enable, per-flag mask {z,o,c,s}
//   result, overflow, carry ALU outputs the flags are captured from
//   push, pop              save / restore flags on the stack
//   cond                   condition code evaluated against stored flags
//   zflag..sflag           registered flags
//   cond_true              combinational condition result
//   stack_full/empty/err   stack status; stack_err is sticky until rst
//
// There is no handshake: every request completes in the cycle it is
// presented and its effect is visible after the next rising clk edge.
module flag_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [3:0]       wmask,
  input  logic [WIDTH-1:0] result,
  input  logic             overflow,
  input  logic             carry,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       cond,
  output logic             zflag,
  output logic             oflag,
  output logic             cflag,
  output logic             sflag,
  output logic             cond_true,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Flags packed as {z,o,c,s}, matching the wmask bit order.
  logic [3:0] flags;
  logic [3:0] wr_val;
  logic [3:0] wr_flags;

  always_comb begin
    wr_val   = {(result == '0), overflow, carry, result[WIDTH-1]};
    wr_flags = (flags & ~wmask) | (wr_val & wmask);
  end

  assign zflag = flags[3];
  assign oflag = flags[2];
  assign cflag = flags[1];
  assign sflag = flags[0];

  // Condition evaluation uses only the registered flags.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = zflag;
      4'd2:  cond_true = !zflag;
      4'd3:  cond_true = cflag;
      4'd4:  cond_true = !cflag;
      4'd5:  cond_true = sflag;
      4'd6:  cond_true = !sflag;
      4'd7:  cond_true = oflag;
      4'd8:  cond_true = !oflag;
      4'd9:  cond_true = cflag & !zflag;
      4'd10: cond_true = !cflag | zflag;
      4'd11: cond_true = (sflag == oflag);
      4'd12: cond_true = (sflag != oflag);
      4'd13: cond_true = !zflag & (sflag == oflag);
      4'd14: cond_true = zflag | (sflag != oflag);
      default: cond_true = 1'b0;
    endcase
  end

`ifdef FLAG_STACK_EN
  // Storage is rounded up to a power of two so the entry index is a plain
  // slice of the count; entries at or beyond DEPTH are never addressed.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    stack_mem [0:(1<<AW)-1];
  logic [CW-1:0] count;
  logic [CW-1:0] top_idx;
  logic          err;
  logic          do_push;
  logic          do_pop;

  // Push and pop together cancel: no stack movement and no error.
  assign do_push = push & ~pop;
  assign do_pop  = pop & ~push;
  assign top_idx = count - 1'b1;

  assign stack_full  = (count == DEPTH_C);
  assign stack_empty = (count == '0);
  assign stack_err   = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
      count <= '0;
      err   <= 1'b0;
    end else begin
      // A pop owns the flag register for the cycle; a coincident write is lost.
      if (do_pop) begin
        if (stack_empty) begin
          err <= 1'b1;
        end else begin
          flags <= stack_mem[top_idx[AW-1:0]];
          count <= top_idx;
        end
      end else if (we) begin
        flags <= wr_flags;
      end

      if (do_push) begin
        if (stack_full) begin
          err <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // The pushed entry is the pre-edge flag value, so a same-cycle write only
  // affects the live flags.
  always_ff @(posedge clk) begin
    if (!rst && do_push && !stack_full) begin
      stack_mem[count[AW-1:0]] <= flags;
    end
  end
`else
  logic unused_stack;
  assign unused_stack = &{1'b0, push, pop, DEPTH_C};

  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (we) begin
      flags <= wr_flags;
    end
  end
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: table-driven write/condition vectors,
// then hand-written stack, collision and reset sequences.
module tb_flag_unit;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  wmask;
  logic [7:0]  result;
  logic [15:0] result16;
  logic        overflow;
  logic        carry;
  logic        push;
  logic        pop;
  logic [3:0]  cond;

  logic zflag, oflag, cflag, sflag, cond_true, stack_full, stack_empty, stack_err;
  logic z16, o16, c16, s16, ct16, full16, empty16, err16;

  int checks;
  int failures;

  logic [3:0] exp_q[$];
  logic [3:0] exp_f;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  flag_unit #(.WIDTH(8), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .we(we), .wmask(wmask), .result(result),
    .overflow(overflow), .carry(carry), .push(push), .pop(pop), .cond(cond),
    .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag),
    .cond_true(cond_true), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  flag_unit #(.WIDTH(16), .DEPTH(4)) u_dut16 (
    .clk(clk), .rst(rst), .we(we), .wmask(wmask), .result(result16),
    .overflow(overflow), .carry(carry), .push(push), .pop(pop), .cond(cond),
    .zflag(z16), .oflag(o16), .cflag(c16), .sflag(s16),
    .cond_true(ct16), .stack_full(full16),
    .stack_empty(empty16), .stack_err(err16)
  );

  wire [3:0] f8  = {zflag, oflag, cflag, sflag};
  wire [3:0] f16 = {z16, o16, c16, s16};

  typedef struct {
    logic       we;
    logic [3:0] wmask;
    logic [7:0] result;
    logic       ovf;
    logic       cry;
    logic [3:0] cond;
    logic [3:0] exp_f;
    logic       exp_c;
  } vec_t;

  vec_t vt[21];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one cycle of requests, then return strobes to idle
  task automatic op(input logic w, input logic [3:0] m, input logic [7:0] r,
                    input logic o, input logic c, input logic pu, input logic po);
    we = w; wmask = m; result = r; overflow = o; carry = c; push = pu; pop = po;
    step();
    we = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; we = 1'b0; wmask = 4'h0; result = 8'h00; result16 = 16'h0000;
    overflow = 1'b0; carry = 1'b0; push = 1'b0; pop = 1'b0; cond = 4'd2;

    // {we, wmask, result, ovf, cry, cond, expected {z,o,c,s}, expected cond_true}
    vt[0]  = '{1'b1, 4'hF, 8'h80, 1'b1, 1'b0, 4'd12, 4'b0101, 1'b0};
    vt[1]  = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd5,  4'b0101, 1'b1};
    vt[2]  = '{1'b1, 4'hF, 8'h00, 1'b0, 1'b1, 4'd1,  4'b1010, 1'b1};
    vt[3]  = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd10, 4'b1010, 1'b1};
    vt[4]  = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd9,  4'b1010, 1'b0};
    vt[5]  = '{1'b1, 4'hF, 8'hFF, 1'b1, 1'b1, 4'd11, 4'b0111, 1'b1};
    vt[6]  = '{1'b1, 4'h4, 8'h00, 1'b0, 1'b0, 4'd13, 4'b0011, 1'b0};
    vt[7]  = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd14, 4'b0011, 1'b1};
    vt[8]  = '{1'b1, 4'hF, 8'h7F, 1'b1, 1'b1, 4'd7,  4'b0110, 1'b1};
    vt[9]  = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd12, 4'b0110, 1'b1};
    vt[10] = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd8,  4'b0110, 1'b0};
    vt[11] = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd3,  4'b0110, 1'b1};
    vt[12] = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd4,  4'b0110, 1'b0};
    vt[13] = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd6,  4'b0110, 1'b1};
    vt[14] = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd2,  4'b0110, 1'b1};
    vt[15] = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd15, 4'b0110, 1'b0};
    vt[16] = '{1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'd0,  4'b0110, 1'b1};
    vt[17] = '{1'b1, 4'hF, 8'h00, 1'b1, 1'b1, 4'd1,  4'b1110, 1'b1};
    vt[18] = '{1'b1, 4'h1, 8'h80, 1'b0, 1'b0, 4'd13, 4'b1111, 1'b0};
    vt[19] = '{1'b1, 4'h8, 8'h01, 1'b0, 1'b0, 4'd13, 4'b0111, 1'b1};
    vt[20] = '{1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 4'd12, 4'b0111, 1'b0};

    // reset state
    step(); step();
    rst = 1'b0;
    step();
    check("reset_flags", {12'h0, f8}, 16'h0000);
    check("reset_empty", {15'h0, stack_empty}, 16'h1);
    check("reset_full", {15'h0, stack_full}, 16'h0);
    check("reset_err", {15'h0, stack_err}, 16'h0);
    check("reset_cond2", {15'h0, cond_true}, 16'h1);
    cond = 4'd15; #1;
    check("reset_cond15", {15'h0, cond_true}, 16'h0);

    // table-driven write and condition vectors
    for (int i = 0; i < 21; i++) begin
      op(vt[i].we, vt[i].wmask, vt[i].result, vt[i].ovf, vt[i].cry, 1'b0, 1'b0);
      cond = vt[i].cond;
      #1;
      check($sformatf("vec%0d_flags", i), {12'h0, f8}, {12'h0, vt[i].exp_f});
      check($sformatf("vec%0d_cond", i), {15'h0, cond_true}, {15'h0, vt[i].exp_c});
    end

    // zero detect spans the full width
    result16 = 16'h0100;
    op(1'b1, 4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w16_0100_flags", {12'h0, f16}, 16'h0000);
    check("w8_00_flags", {12'h0, f8}, 16'h0008);
    result16 = 16'h8000;
    op(1'b1, 4'hF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w16_8000_flags", {12'h0, f16}, 16'h0001);
    check("w8_01_flags", {12'h0, f8}, 16'h0000);
    result16 = 16'h0000;
    op(1'b1, 4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w16_0000_flags", {12'h0, f16}, 16'h0008);

`ifdef FLAG_STACK_EN
    do_reset();
    // fill DEPTH=2 stack with 0101 then 1010
    op(1'b1, 4'hF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(4'b0101);
    check("push1_empty", {15'h0, stack_empty}, 16'h0);
    check("push1_full", {15'h0, stack_full}, 16'h0);
    op(1'b1, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("write_1010", {12'h0, f8}, 16'h000A);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(4'b1010);
    check("push2_full", {15'h0, stack_full}, 16'h1);
    check("push2_err", {15'h0, stack_err}, 16'h0);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("push3_err", {15'h0, stack_err}, 16'h1);
    check("push3_full", {15'h0, stack_full}, 16'h1);
    check("push3_flags", {12'h0, f8}, 16'h000A);
    for (int k = 0; k < 2; k++) begin
      op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_f = exp_q.pop_back();
      check($sformatf("pop%0d_flags", k), {12'h0, f8}, {12'h0, exp_f});
    end
    check("pop_empty", {15'h0, stack_empty}, 16'h1);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("underflow_flags", {12'h0, f8}, 16'h0005);
    check("underflow_err", {15'h0, stack_err}, 16'h1);
    do_reset();
    check("err_cleared", {15'h0, stack_err}, 16'h0);

    // we with pop: the stack wins
    op(1'b1, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    op(1'b1, 4'hF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    check("we_pop_flags", {12'h0, f8}, 16'h000A);
    check("we_pop_empty", {15'h0, stack_empty}, 16'h1);

    // we with push: stack keeps the old flags
    op(1'b1, 4'hF, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    check("we_push_live", {12'h0, f8}, 16'h0005);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("we_push_saved", {12'h0, f8}, 16'h000A);

    // push with pop: count unchanged, write still applies
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    op(1'b1, 4'hF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    check("pushpop_flags", {12'h0, f8}, 16'h000E);
    check("pushpop_empty", {15'h0, stack_empty}, 16'h0);
    check("pushpop_full", {15'h0, stack_full}, 16'h0);
    check("pushpop_err", {15'h0, stack_err}, 16'h0);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pushpop_then_full", {15'h0, stack_full}, 16'h1);
    check("pushpop_then_err", {15'h0, stack_err}, 16'h0);

    // reset coincident with a pop
    do_reset();
    op(1'b1, 4'hF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_rst_err", {15'h0, stack_err}, 16'h1);
    rst = 1'b1; pop = 1'b1;
    step();
    rst = 1'b0; pop = 1'b0;
    check("rst_pop_flags", {12'h0, f8}, 16'h0000);
    check("rst_pop_empty", {15'h0, stack_empty}, 16'h1);
    check("rst_pop_full", {15'h0, stack_full}, 16'h0);
    check("rst_pop_err", {15'h0, stack_err}, 16'h0);
`else
    // stack disabled: push/pop are no-ops and never block a write
    do_reset();
    op(1'b1, 4'hF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("nostk_push%0d_flags", k), {12'h0, f8}, 16'h0005);
      check($sformatf("nostk_push%0d_empty", k), {15'h0, stack_empty}, 16'h1);
    end
    op(1'b1, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    check("nostk_we_pop", {12'h0, f8}, 16'h000A);
    op(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("nostk_pop_flags", {12'h0, f8}, 16'h000A);
    check("nostk_empty", {15'h0, stack_empty}, 16'h1);
    check("nostk_full", {15'h0, stack_full}, 16'h0);
    check("nostk_err", {15'h0, stack_err}, 16'h0);
    rst = 1'b1; pop = 1'b1;
    step();
    rst = 1'b0; pop = 1'b0;
    check("nostk_rst_flags", {12'h0, f8}, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Parametrised status-flag unit that succeeds the fixed 8-bit compare-flag register. It captures Z/O/C/S from an ALU result of configurable width under a per-flag write mask. It evaluates a 4-bit branch condition code against the stored flags. It provides a small LIFO flag stack so interrupt entry and exit can save and restore flags. The unit sits between the ALU and the control/jump logic of the CPU core.

## Interface
Parameters:
- WIDTH, 8, ALU result width in bits (≥2)
- DEPTH, 4, flag-stack entries (≥1); counter width is $clog2(DEPTH+1)

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  reset; synchronous, active-high, sampled on rising clk
- we  in  1  flag write enable
- wmask  in  4  per-flag write mask {z,o,c,s}; only bits set to 1 are updated
- result  in  WIDTH  ALU result
- overflow  in  1  ALU overflow
- carry  in  1  ALU carry
- push  in  1  save current flags to stack
- pop  in  1  restore flags from stack
- cond  in  4  condition code to evaluate
- zflag, oflag, cflag, sflag  out  1 each  registered flags
- cond_true  out  1  combinational result of cond against registered flags
- stack_full  out  1  count == DEPTH
- stack_empty  out  1  count == 0
- stack_err  out  1  sticky overflow/underflow error

## Operation
- Flag write (we=1, no pop): for each masked bit, set:
  - z ← (result == 0), using all WIDTH bits
  - o ← overflow
  - c ← carry
  - s ← result[WIDTH-1]
  - Unmasked flags hold.
- Push (push=1, pop=0):
  - If not full: stack[count] ← {z,o,c,s} as they were before this edge; count+1.
  - If full: push is dropped and stack_err ← 1.
- Pop (pop=1, push=0):
  - If not empty: flags ← stack[count-1]; count-1.
  - If empty: flags are unchanged and stack_err ← 1.
- Simultaneous events:
  - push and pop together: no stack operation, no error; we still applies.
  - we and pop: pop wins; the flag write is discarded.
  - we and push: the stack saves the pre-write flags; the write applies to the live flags.
- stack_err is sticky and is cleared only by rst.
- Condition codes (cond → cond_true):
  - 0 always; 1 z; 2 !z; 3 c; 4 !c; 5 s; 6 !s; 7 o
  - 8 !o; 9 c&!z; 10 !c|z; 11 s==o; 12 s!=o
  - 13 !z&(s==o); 14 z|(s!=o); 15 never

## Timing
- Reset: all four flags 0, count 0, stack_err 0. Outputs after reset: stack_empty=1, stack_full=0, and cond_true reflects zero flags (e.g. cond=2 gives 1). Stack contents are don't-care.
- rst asserted during any operation overrides it on the same edge; a push, pop or write that cycle is lost.
- Flags, count and stack_err update on the rising clk edge and are visible in the following cycle (1-cycle latency).
- cond_true is purely combinational from cond and the registered flags; it never depends on this cycle's result or we.
- No handshake; every request completes in one cycle. Back-to-back push/pop on consecutive cycles is supported at full rate.

## Configuration
- FLAG_STACK_EN defined: stack, count, push/pop logic and stack_err are implemented as above.
- FLAG_STACK_EN undefined:
  - No stack storage; push and pop are ignored (pop never blocks we).
  - stack_full=0, stack_empty=1 and stack_err=0 are tied constant.
  - The DEPTH parameter is accepted but unused.

## Test plan
- Reset then write: rst, then we=1, wmask=4'b1111, WIDTH=8, result=8'h80, overflow=1, carry=0 → next cycle z=0, o=1, c=0, s=1; cond=12 (lt) gives cond_true=0, cond=5 gives 1.
- Zero uses full width: result=8'h80 gives z=0; result=8'h00 gives z=1. WIDTH=16 with result=16'h0100 gives z=0.
- Mask: flags 1111, then we=1, wmask=4'b1000, result=8'h01 → z=0 while o, c, s stay 1.
- Stack with DEPTH=2:
  - Flags 0101; push; write flags to 1010; push.
  - Third push → stack_err=1, stack_full stays 1.
  - Pop twice → flags 1010, then 0101; stack_empty=1.
  - Further pop → flags unchanged, stack_err stays 1.
- Collisions:
  - we with pop → flags come from the stack, not the result.
  - we with push → stack entry holds the old flags, live flags hold the new ones.
  - push with pop → count unchanged.
- Mid-operation reset: push three entries, assert rst coincident with a pop → flags 0000, count 0, stack_err 0. Build without FLAG_STACK_EN → push/pop are no-ops and stack_empty=1 throughout.
